multi_debouncer: RTL and testbench
==================================

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent channels (1..32).
REQ-002 SHALL have parameter CLOCK_FREQ_HZ, default 100000000, input clock frequency.
REQ-003 SHALL have parameter DEBOUNCE_CLOCK_HZ, default 1000000, sample tick rate.
REQ-004 SHALL have parameter STABLE_SAMPLES, default 4, consecutive mismatching samples required to change an output (1..255).
REQ-005 SHALL have parameter INIT_VAL, default all zeros, NUM_CH-bit reset value of synchronizers and outputs.
REQ-006 SHALL have parameter SIMULATE, default 0; nonzero forces the tick divider DIV = 6.
REQ-007 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-009 SHALL have port en  input  1  high = debounce active; low = freeze.
REQ-010 SHALL have port din  input  NUM_CH  raw asynchronous inputs (switches, buttons).
REQ-011 SHALL have port dout  output  NUM_CH  debounced levels, registered.
REQ-012 SHALL have port rise  output  NUM_CH  one-cycle pulse on dout 0->1, registered.
REQ-013 SHALL have port fall  output  NUM_CH  one-cycle pulse on dout 1->0, registered.
REQ-014 SHALL have port any_change  output  1  registered OR of all rise and fall bits.

Function
REQ-015 DIV SHALL be CLOCK_FREQ_HZ/DEBOUNCE_CLOCK_HZ (integer division) when SIMULATE==0, else 6; DIV < 2 is illegal.
REQ-016 A shared prescaler SHALL count 0..DIV-1 and wrap to 0 while en=1; tick is asserted in the cycle prescaler==DIV-1 and en=1.
REQ-017 Each din bit SHALL pass through a two-flop synchronizer (s1, s2); only s2 is used by the debounce logic.
REQ-018 Each channel SHALL have a counter of width clog2(STABLE_SAMPLES+1); counters SHALL change only on tick.
REQ-019 On tick, if s2[i]==dout[i], cnt[i] SHALL clear to 0 (bounce rejection).
REQ-020 On tick, if s2[i]!=dout[i] and cnt[i]==STABLE_SAMPLES-1, dout[i] SHALL load s2[i] and cnt[i] SHALL clear to 0.
REQ-021 On tick, if s2[i]!=dout[i] and cnt[i]<STABLE_SAMPLES-1, cnt[i] SHALL increment by 1; the counter SHALL never exceed STABLE_SAMPLES-1.
REQ-022 rise[i]/fall[i] SHALL assert for exactly the one cycle following the clock edge at which dout[i] changes, and SHALL be 0 in all other cycles.
REQ-023 Multiple channels flipping on the same tick SHALL each pulse independently; any_change SHALL assert for that same single cycle.
REQ-024 With en=0, the prescaler, counters and dout SHALL hold, rise/fall/any_change SHALL be 0, and synchronizers SHALL keep sampling; on en returning to 1 the prescaler SHALL resume from its held value.
REQ-025 A level held stable on din[i] SHALL appear on dout[i] between 2+(STABLE_SAMPLES-1)*DIV+1 and 2+STABLE_SAMPLES*DIV cycles after the change.
REQ-026 A level change lasting fewer than (STABLE_SAMPLES-1)*DIV cycles SHALL never propagate to dout.

Reset
REQ-027 While reset=0 at a rising edge: prescaler=0, all cnt=0, s1=s2=INIT_VAL, dout=INIT_VAL, rise=fall=0, any_change=0.
REQ-028 Reset SHALL take priority over en and tick; asserting it mid-count SHALL discard partial counts, and no edge pulse SHALL be generated from the reset-induced dout change.
REQ-029 After release, the first tick SHALL occur at the DIV-th rising edge with reset=1 and en=1.

Verification (SIMULATE=1, NUM_CH=4, STABLE_SAMPLES=3, INIT_VAL=4'b0000, DIV=6)
REQ-030 Clean edge: din[0] 0->1 held -> dout[0]=1 between 15 and 20 cycles later, rise[0] high exactly 1 cycle, any_change high the same cycle, fall=0.
REQ-031 Bounce: din[1] goes to 1 for 12 cycles then returns to 0, repeated 5 times -> dout[1] stays 0, no pulses.
REQ-032 Simultaneous: din[3:2] 00->11 on the same cycle -> dout[3:2] both change on the same edge, rise=4'b1100 for one cycle.
REQ-033 Freeze: set en=0 after 2 ticks of mismatch on din[0], hold for 50 cycles, then set en=1 -> dout[0] flips on the 1st tick after resume, not during the freeze.
REQ-034 Reset mid-count: din[0]=1 for 2 ticks, pulse reset low for 1 cycle -> all outputs 0, and dout[0] then rises only after a full 3-tick qualification.
REQ-035 Release/INIT_VAL: with INIT_VAL=4'b1111 and din=4'b1111, releasing reset -> dout=4'b1111 with no rise/fall pulses during 100 cycles.

Source files
------------

// File: rtl/multi_debouncer.sv
// Multi-channel switch debouncer: two-flop synchronizer per input, shared sample-tick
// prescaler, per-channel stability counter, registered level and edge-pulse outputs.
module multi_debouncer #(
    parameter int                NUM_CH            = 4,
    parameter int                CLOCK_FREQ_HZ     = 100000000,
    parameter int                DEBOUNCE_CLOCK_HZ = 1000000,
    parameter int                STABLE_SAMPLES    = 4,
    parameter logic [NUM_CH-1:0] INIT_VAL          = {NUM_CH{1'b0}},
    parameter int                SIMULATE          = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [NUM_CH-1:0] din,
    output logic [NUM_CH-1:0] dout,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic              any_change
);

    localparam int DIV = (SIMULATE != 32'sd0) ? 32'sd6 : (CLOCK_FREQ_HZ / DEBOUNCE_CLOCK_HZ);
    localparam int PW  = (DIV > 32'sd1) ? $clog2(DIV) : 32'sd1;
    localparam int CW  = $clog2(STABLE_SAMPLES + 32'sd1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 32'sd1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_SAMPLES - 32'sd1);

    logic [PW-1:0]     presc_r;
    logic [PW-1:0]     presc_nxt_s;
    logic              tick_s;
    logic [NUM_CH-1:0] s1_r;
    logic [NUM_CH-1:0] s2_r;
    logic [CW-1:0]     cnt_r     [NUM_CH];
    logic [CW-1:0]     cnt_nxt_s [NUM_CH];
    logic [NUM_CH-1:0] dout_r;
    logic [NUM_CH-1:0] dout_nxt_s;
    logic [NUM_CH-1:0] rise_r;
    logic [NUM_CH-1:0] fall_r;
    logic              any_r;

    assign tick_s = en && (presc_r == PRESC_LAST);

    // Prescaler advances only while enabled, so a freeze resumes mid-period.
    always_comb begin
        presc_nxt_s = presc_r;
        if (!en) begin
            presc_nxt_s = presc_r;
        end else if (presc_r == PRESC_LAST) begin
            presc_nxt_s = {PW{1'b0}};
        end else begin
            presc_nxt_s = presc_r + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Per-channel qualification: any matching sample restarts the run of mismatches.
    always_comb begin
        dout_nxt_s = dout_r;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (!tick_s) begin
                cnt_nxt_s[i] = cnt_r[i];
            end else if (s2_r[i] == dout_r[i]) begin
                cnt_nxt_s[i] = {CW{1'b0}};
            end else if (cnt_r[i] == CNT_LAST) begin
                dout_nxt_s[i] = s2_r[i];
                cnt_nxt_s[i]  = {CW{1'b0}};
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    // State and output registers; reset wins over en/tick and emits no edge pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_r <= {PW{1'b0}};
            s1_r    <= INIT_VAL;
            s2_r    <= INIT_VAL;
            dout_r  <= INIT_VAL;
            rise_r  <= {NUM_CH{1'b0}};
            fall_r  <= {NUM_CH{1'b0}};
            any_r   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else begin
            presc_r <= presc_nxt_s;
            s1_r    <= din;
            s2_r    <= s1_r;
            dout_r  <= dout_nxt_s;
            rise_r  <= dout_nxt_s & ~dout_r;
            fall_r  <= ~dout_nxt_s & dout_r;
            any_r   <= |(dout_nxt_s ^ dout_r);
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign dout       = dout_r;
    assign rise       = rise_r;
    assign fall       = fall_r;
    assign any_change = any_r;

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: directed scenarios plus random stimulus,
// all compared cycle by cycle against a behavioural model of the debounce rules.
module tb_multi_debouncer;

    localparam int DIV = 6;
    localparam int SS  = 3;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] din;
    logic [3:0] dout, rise, fall;
    logic       any_change;
    logic [3:0] din_hi;
    logic [3:0] dout_hi, rise_hi, fall_hi;
    logic       any_hi;

    int checks = 0;
    int errors = 0;

    // Behavioural model: input history, tick phase, run of mismatching samples per channel.
    logic [3:0] m_s1, m_s2, m_dout, m_rise, m_fall;
    logic       m_any;
    int         m_phase;
    int         m_run [4];

    multi_debouncer #(
        .NUM_CH(4), .CLOCK_FREQ_HZ(100000000), .DEBOUNCE_CLOCK_HZ(1000000),
        .STABLE_SAMPLES(SS), .INIT_VAL(4'b0000), .SIMULATE(1)
    ) u_dut (
        .clk(clk), .reset(reset), .en(en), .din(din),
        .dout(dout), .rise(rise), .fall(fall), .any_change(any_change)
    );

    multi_debouncer #(
        .NUM_CH(4), .CLOCK_FREQ_HZ(100000000), .DEBOUNCE_CLOCK_HZ(1000000),
        .STABLE_SAMPLES(SS), .INIT_VAL(4'b1111), .SIMULATE(1)
    ) u_dut_hi (
        .clk(clk), .reset(reset), .en(en), .din(din_hi),
        .dout(dout_hi), .rise(rise_hi), .fall(fall_hi), .any_change(any_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge(input logic r, input logic e, input logic [3:0] d);
        logic [3:0] old;
        bit         tick;
        if (!r) begin
            m_phase = 0;
            m_s1 = 4'b0000; m_s2 = 4'b0000; m_dout = 4'b0000;
            m_rise = 4'b0000; m_fall = 4'b0000; m_any = 1'b0;
            for (int c = 0; c < 4; c++) m_run[c] = 0;
        end else begin
            old  = m_dout;
            tick = e && (m_phase == DIV - 1);
            if (e) m_phase = (m_phase + 1) % DIV;
            if (tick) begin
                for (int c = 0; c < 4; c++) begin
                    if (m_s2[c] == m_dout[c]) begin
                        m_run[c] = 0;
                    end else begin
                        m_run[c] = m_run[c] + 1;
                        if (m_run[c] == SS) begin
                            m_dout[c] = m_s2[c];
                            m_run[c]  = 0;
                        end
                    end
                end
            end
            m_rise = m_dout & ~old;
            m_fall = ~m_dout & old;
            m_any  = (m_dout != old);
            m_s2   = m_s1;
            m_s1   = d;
        end
    endtask

    task automatic cycle();
        logic r, e;
        logic [3:0] d;
        r = reset; e = en; d = din;
        @(posedge clk);
        model_edge(r, e, d);
        #1;
        checks++;
        if ({dout, rise, fall, any_change} !== {m_dout, m_rise, m_fall, m_any}) begin
            errors++;
            $display("FAIL model_cycle t=%0t: got dout=%b rise=%b fall=%b any=%b, expected dout=%b rise=%b fall=%b any=%b",
                     $time, dout, rise, fall, any_change, m_dout, m_rise, m_fall, m_any);
        end
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; din = 4'b0000;
        settle(3);
        checks++;
        if ({dout, rise, fall, any_change} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: got %b, expected all zero", {dout, rise, fall, any_change});
        end
        reset = 1'b1;
        settle(10);
    endtask

    task automatic test_clean_edge();
        int n;
        din = 4'b0001;
        n = 0;
        while (dout[0] !== 1'b1 && n < 40) begin cycle(); n++; end
        checks++;
        if (n < 15 || n > 20) begin
            errors++;
            $display("FAIL clean_latency: got %0d cycles, expected 15..20", n);
        end
        checks++;
        if ({rise, fall, any_change} !== 9'b0001_0000_1) begin
            errors++;
            $display("FAIL clean_pulse: got rise=%b fall=%b any=%b, expected rise=0001 fall=0000 any=1", rise, fall, any_change);
        end
        cycle();
        checks++;
        if ({rise, any_change} !== 5'b0000_0) begin
            errors++;
            $display("FAIL clean_one_cycle: got rise=%b any=%b, expected 0000/0", rise, any_change);
        end
        settle(10);
    endtask

    task automatic test_bounce();
        for (int rep = 0; rep < 5; rep++) begin
            for (int ph = 0; ph < 24; ph++) begin
                din[1] = (ph < 12);
                cycle();
                checks++;
                if (dout[1] !== 1'b0 || rise !== 4'b0000 || fall !== 4'b0000) begin
                    errors++;
                    $display("FAIL bounce: got dout=%b rise=%b fall=%b, expected dout[1]=0 and no pulses", dout, rise, fall);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int n;
        din = 4'b1101;
        n = 0;
        while (dout[3:2] === 2'b00 && n < 40) begin cycle(); n++; end
        checks++;
        if (dout !== 4'b1101 || rise !== 4'b1100 || any_change !== 1'b1) begin
            errors++;
            $display("FAIL simultaneous: got dout=%b rise=%b any=%b, expected dout=1101 rise=1100 any=1", dout, rise, any_change);
        end
        din = 4'b0000;
        settle(30);
    endtask

    task automatic test_freeze();
        int n, expect_n;
        din = 4'b0001;
        n = 0;
        while (m_run[0] != 2 && n < 40) begin cycle(); n++; end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL freeze_setup: got timeout after %0d cycles, expected two mismatching ticks", n);
        end
        en = 1'b0;
        for (int k = 0; k < 50; k++) begin
            cycle();
            checks++;
            if (dout[0] !== 1'b0 || {rise, fall, any_change} !== 9'd0) begin
                errors++;
                $display("FAIL freeze_hold: got dout=%b rise=%b fall=%b any=%b, expected dout[0]=0 no pulses",
                         dout, rise, fall, any_change);
            end
        end
        en = 1'b1;
        expect_n = DIV - m_phase;
        n = 0;
        while (dout[0] !== 1'b1 && n < 40) begin cycle(); n++; end
        checks++;
        if (n != expect_n) begin
            errors++;
            $display("FAIL freeze_resume: got flip after %0d cycles, expected %0d", n, expect_n);
        end
        settle(5);
    endtask

    task automatic test_reset_mid();
        int n;
        din = 4'b0100;
        settle(40);
        din = 4'b0101;
        n = 0;
        while (m_run[0] != 2 && n < 40) begin cycle(); n++; end
        reset = 1'b0;
        cycle();
        checks++;
        if ({dout, rise, fall, any_change} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid: got dout=%b rise=%b fall=%b any=%b, expected all zero", dout, rise, fall, any_change);
        end
        reset = 1'b1;
        n = 0;
        while (dout[0] !== 1'b1 && n < 40) begin cycle(); n++; end
        checks++;
        if (n != SS * DIV || rise !== 4'b0101) begin
            errors++;
            $display("FAIL reset_requalify: got %0d cycles rise=%b, expected %0d cycles rise=0101", n, rise, SS * DIV);
        end
        din = 4'b0000;
        settle(30);
    endtask

    task automatic test_init_val();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        for (int k = 0; k < 100; k++) begin
            cycle();
            checks++;
            if (dout_hi !== 4'b1111 || rise_hi !== 4'b0000 || fall_hi !== 4'b0000 || any_hi !== 1'b0) begin
                errors++;
                $display("FAIL init_val: got dout=%b rise=%b fall=%b any=%b, expected 1111/0000/0000/0",
                         dout_hi, rise_hi, fall_hi, any_hi);
            end
        end
    endtask

    task automatic test_random();
        int k;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                k = $urandom_range(3, 0);
                din[k] = ~din[k];
            end
            if ($urandom_range(0, 79) == 0) en = ~en;
            reset = ($urandom_range(0, 599) != 0);
            cycle();
        end
        reset = 1'b1;
        en = 1'b1;
        settle(30);
    endtask

    initial begin
        reset  = 1'b0;
        en     = 1'b1;
        din    = 4'b0000;
        din_hi = 4'b1111;
        test_reset();
        test_clean_edge();
        test_bounce();
        test_simultaneous();
        test_freeze();
        test_reset_mid();
        test_init_val();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
